// File: rtl/hyper_cmd_seq.sv
// ---------------------------------------------------------------------------
// hyper_cmd_seq
//
// Command sequencer that sits in front of the hyper_xface HyperRAM
// controller. After reset it waits out the HyperRAM power-up time and writes
// configuration register CR0. It then turns each host command into exactly
// one rd_req/wr_req transaction. Read dwords are buffered in a response FIFO
// so the host can apply back-pressure even though the controller cannot.
//
// Ports
//   clk, reset_l              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       host command handshake
//   cmd_op                    00 read mem, 01 write mem, 10 write reg, 11 illegal
//   cmd_addr/cmd_data/cmd_be  dword address, write data, write byte enables
//   cmd_len                   read length in dwords (0 is treated as 1)
//   rsp_valid/rsp_ready       read-data handshake
//   rsp_data/rsp_last         read dword, last-dword-of-command marker
//   init_done                 CR0 write completed (stays high)
//   cmd_err                   sticky error flag, cleared only by reset
//   rd_req/wr_req             single-cycle request pulses to the controller
//   mem_or_reg                0 = memory space, 1 = register space
//   wr_byte_en/rd_num_dwords/addr/wr_d   request fields, held between issues
//   rd_d/rd_rdy/busy          controller read data, read strobe, busy
//   latency_1x/latency_2x     constant latency settings
// ---------------------------------------------------------------------------
module hyper_cmd_seq #(
    parameter int          INIT_CYCLES = 24900,
    parameter logic [31:0] CR0_ADDR    = 32'h0000_0800,
    parameter logic [15:0] CR0_VALUE   = 16'h8F1F,
    parameter logic [7:0]  LAT_1X      = 8'h10,
    parameter logic [7:0]  LAT_2X      = 8'd22,
    parameter int          RSP_DEPTH   = 32
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_be,
    input  logic [5:0]  cmd_len,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        init_done,
    output logic        cmd_err,
    output logic        rd_req,
    output logic        wr_req,
    output logic        mem_or_reg,
    output logic [3:0]  wr_byte_en,
    output logic [5:0]  rd_num_dwords,
    output logic [31:0] addr,
    output logic [31:0] wr_d,
    input  logic [31:0] rd_d,
    input  logic        rd_rdy,
    input  logic        busy,
    output logic [7:0]  latency_1x,
    output logic [7:0]  latency_2x
);

    localparam int          AW        = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [31:0] INIT_LAST = 32'(INIT_CYCLES - 1);
    localparam logic [31:0] DEPTH_W   = 32'(RSP_DEPTH);
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

    localparam logic [1:0] OP_RD_MEM  = 2'b00;
    localparam logic [1:0] OP_WR_MEM  = 2'b01;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        S_INIT_WAIT,
        S_INIT_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_IDLE,
        S_ISSUE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] init_cnt;

    // Latched host command
    logic [1:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  be_q;
    logic [5:0]  len_q;

    // Outstanding-read tracking
    logic        rd_active;
    logic [5:0]  rcv_cnt;

    // Response FIFO: {last, data}
    logic [32:0] fifo_mem [RSP_DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] occ;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;

    // FSM strobes
    logic        accept;
    logic        init_fire;
    logic        issue_fire;
    logic        done_exit;

    logic [5:0]  cmd_len_eff;
    logic        cmd_illegal;
    logic [31:0] free_space;
    logic        issue_ok;
    logic        rd_push;
    logic        rd_last_push;

    assign latency_1x = LAT_1X;
    assign latency_2x = LAT_2X;

    assign cmd_len_eff = (cmd_len == 6'd0) ? 6'd1 : cmd_len;
    assign cmd_illegal = (cmd_op == OP_ILLEGAL) || (32'(cmd_len_eff) > DEPTH_W);

    // Nothing else can be in flight while in ISSUE, so free space alone
    // guarantees the whole burst fits and the FIFO cannot overflow.
    assign occ        = wptr - rptr;
    assign free_space = DEPTH_W - 32'(occ);
    assign issue_ok   = !busy && ((op_q != OP_RD_MEM) || (32'(len_q) <= free_space));

    assign rd_push      = rd_rdy && rd_active;
    assign rd_last_push = rd_push && ((rcv_cnt + 6'd1) == len_q);

    // ------------------------------------------------------------------
    // FSM: state register and init counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state    <= S_INIT_WAIT;
            init_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_INIT_WAIT) begin
                init_cnt <= init_cnt + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        accept     = 1'b0;
        init_fire  = 1'b0;
        issue_fire = 1'b0;
        done_exit  = 1'b0;
        case (state)
            S_INIT_WAIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_next = S_INIT_ISSUE;
                end
            end
            S_INIT_ISSUE: begin
                if (!busy) begin
                    init_fire  = 1'b1;
                    state_next = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (busy) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // A final dword arriving on the exit edge still completes the read.
                if (!busy && (!rd_active || rd_last_push)) begin
                    done_exit  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                cmd_ready = init_done;
                if (cmd_valid && init_done) begin
                    accept = 1'b1;
                    if (!cmd_illegal) begin
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (issue_ok) begin
                    issue_fire = 1'b1;
                    state_next = S_WAIT_BUSY;
                end
            end
            default: state_next = S_INIT_WAIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Command latch, init_done and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            op_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            len_q     <= '0;
            init_done <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            if (accept && !cmd_illegal) begin
                op_q   <= cmd_op;
                addr_q <= cmd_addr;
                data_q <= cmd_data;
                be_q   <= cmd_be;
                len_q  <= cmd_len_eff;
            end
            if (done_exit) begin
                init_done <= 1'b1;
            end
            if ((accept && cmd_illegal) || (rd_rdy && !rd_active)) begin
                cmd_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Controller request outputs: pulses plus fields held until next issue
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            rd_req        <= 1'b0;
            wr_req        <= 1'b0;
            mem_or_reg    <= 1'b0;
            addr          <= '0;
            wr_d          <= '0;
            wr_byte_en    <= '0;
            rd_num_dwords <= '0;
        end else begin
            rd_req <= 1'b0;
            wr_req <= 1'b0;
            if (init_fire) begin
                wr_req     <= 1'b1;
                mem_or_reg <= 1'b1;
                addr       <= CR0_ADDR;
                wr_d       <= {CR0_VALUE, 16'h0000};
                wr_byte_en <= 4'hC;
            end else if (issue_fire) begin
                addr <= addr_q;
                case (op_q)
                    OP_RD_MEM: begin
                        rd_req        <= 1'b1;
                        mem_or_reg    <= 1'b0;
                        rd_num_dwords <= len_q;
                    end
                    OP_WR_MEM: begin
                        wr_req     <= 1'b1;
                        mem_or_reg <= 1'b0;
                        wr_d       <= data_q;
                        wr_byte_en <= be_q;
                    end
                    default: begin
                        wr_req     <= 1'b1;
                        mem_or_reg <= 1'b1;
                        wr_d       <= data_q;
                        wr_byte_en <= 4'hF;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outstanding read: dword counter, cleared by the final push
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            rd_active <= 1'b0;
            rcv_cnt   <= '0;
        end else begin
            if (issue_fire && (op_q == OP_RD_MEM)) begin
                rd_active <= 1'b1;
                rcv_cnt   <= '0;
            end else if (rd_push) begin
                rcv_cnt <= rcv_cnt + 6'd1;
                if (rd_last_push) begin
                    rd_active <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push       = rd_push && !fifo_full;
    assign pop        = rsp_valid && rsp_ready;

    assign rsp_valid = !fifo_empty;
    // Gated so the outputs read zero while empty, including right after reset.
    assign rsp_data  = fifo_empty ? 32'h0 : fifo_mem[rptr[AW-1:0]][31:0];
    assign rsp_last  = fifo_empty ? 1'b0  : fifo_mem[rptr[AW-1:0]][32];

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr[AW-1:0]] <= {rd_last_push, rd_d};
        end
    end

endmodule

// File: tb/tb_hyper_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_hyper_cmd_seq
//
// Bench for hyper_cmd_seq with INIT_CYCLES=20 and RSP_DEPTH=32. A behavioural
// controller model answers requests; a reference memory built from the host
// commands predicts every response dword and every request field.
// ---------------------------------------------------------------------------
module tb_hyper_cmd_seq;

    localparam int DEPTH = 32;
    localparam logic [1:0] OP_RD = 2'b00, OP_WR = 2'b01, OP_WREG = 2'b10, OP_BAD = 2'b11;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic [3:0]  cmd_be = '0;
    logic [5:0]  cmd_len = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        init_done;
    logic        cmd_err;
    logic        rd_req;
    logic        wr_req;
    logic        mem_or_reg;
    logic [3:0]  wr_byte_en;
    logic [5:0]  rd_num_dwords;
    logic [31:0] addr;
    logic [31:0] wr_d;
    logic [31:0] rd_d = '0;
    logic        rd_rdy = 1'b0;
    logic        busy = 1'b0;
    logic [7:0]  latency_1x;
    logic [7:0]  latency_2x;

    hyper_cmd_seq #(
        .INIT_CYCLES (20),
        .RSP_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .reset_l       (reset_l),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .cmd_be        (cmd_be),
        .cmd_len       (cmd_len),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_last      (rsp_last),
        .init_done     (init_done),
        .cmd_err       (cmd_err),
        .rd_req        (rd_req),
        .wr_req        (wr_req),
        .mem_or_reg    (mem_or_reg),
        .wr_byte_en    (wr_byte_en),
        .rd_num_dwords (rd_num_dwords),
        .addr          (addr),
        .wr_d          (wr_d),
        .rd_d          (rd_d),
        .rd_rdy        (rd_rdy),
        .busy          (busy),
        .latency_1x    (latency_1x),
        .latency_2x    (latency_2x)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic        reg_sp;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [5:0]  len;
    } req_t;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int rd_pulses = 0;
    int pop_cnt = 0;
    int spur_req = 0;
    int spur_done = 0;
    bit bp_rand = 1'b0;

    req_t        exp_req[$];
    logic [32:0] exp_rsp[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] cmem    [logic [31:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Background content of never-written memory.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // ---------------- controller model (acts on the falling edge) ----------
    int          m_left = 0;
    int          m_wait = 0;
    logic [31:0] m_addr = '0;
    req_t        er;

    always @(negedge clk) begin
        rd_rdy = 1'b0;
        if (!reset_l) begin
            busy   = 1'b0;
            m_left = 0;
            m_wait = 0;
        end else if (rd_req || wr_req) begin
            req_cnt++;
            check("req_expected", 64'(exp_req.size() != 0), 64'd1);
            if (exp_req.size() != 0) begin
                er = exp_req.pop_front();
                check("req_kind", 64'({rd_req, wr_req}), 64'({er.rd, !er.rd}));
                check("req_space", 64'(mem_or_reg), 64'(er.reg_sp));
                check("req_addr", 64'(addr), 64'(er.a));
                if (er.rd) begin
                    check("req_len", 64'(rd_num_dwords), 64'(er.len));
                end else begin
                    check("req_wdata", 64'(wr_d), 64'(er.d));
                    check("req_be", 64'(wr_byte_en), 64'(er.be));
                end
            end
            busy = 1'b1;
            if (rd_req) begin
                m_left = int'(rd_num_dwords);
                m_addr = addr;
                m_wait = int'($urandom_range(1, 3));
            end else begin
                if (!mem_or_reg)
                    cmem[addr] = merge(cmem.exists(addr) ? cmem[addr] : pat(addr), wr_d, wr_byte_en);
                m_wait = int'($urandom_range(2, 4));
            end
        end else if (busy) begin
            if (m_wait > 0) begin
                m_wait--;
            end else if (m_left > 0) begin
                rd_d   = cmem.exists(m_addr) ? cmem[m_addr] : pat(m_addr);
                rd_rdy = 1'b1;
                rd_pulses++;
                m_addr = m_addr + 32'd1;
                m_left--;
                // busy drops together with the last dword
                if (m_left == 0) busy = 1'b0;
                else m_wait = int'($urandom_range(0, 2));
            end else begin
                busy = 1'b0;
            end
        end else if (spur_req != spur_done) begin
            rd_d   = 32'hBAD0_BAD0;
            rd_rdy = 1'b1;
            spur_done++;
        end
    end

    // ---------------- response consumer (falling edge) ---------------------
    logic [32:0] er_rsp;
    always @(negedge clk) begin
        if (reset_l && rsp_valid && rsp_ready) begin
            pop_cnt++;
            check("rsp_expected", 64'(exp_rsp.size() != 0), 64'd1);
            if (exp_rsp.size() != 0) begin
                er_rsp = exp_rsp.pop_front();
                check("rsp_data", 64'(rsp_data), 64'(er_rsp[31:0]));
                check("rsp_last", 64'(rsp_last), 64'(er_rsp[32]));
            end
        end
    end

    // ---------------- host-side helpers ------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_rand) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic [5:0] len);
        int   t;
        logic [31:0] v;
        req_t r;
        t = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_be = be; cmd_len = len;
        while (!cmd_ready && t < 3000) begin tick(); t++; end
        check("cmd_accept_timeout", 64'(t < 3000), 64'd1);
        tick();
        cmd_valid = 1'b0;
        if (op == OP_BAD || int'(len) > DEPTH) return;
        r = '{rd: (op == OP_RD), reg_sp: (op == OP_WREG), a: a, d: d,
              be: (op == OP_WREG) ? 4'hF : be, len: len};
        exp_req.push_back(r);
        if (op == OP_WR) begin
            ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : pat(a), d, be);
        end else if (op == OP_RD) begin
            for (int i = 0; i < int'(len); i++) begin
                v = ref_mem.exists(a + 32'(i)) ? ref_mem[a + 32'(i)] : pat(a + 32'(i));
                exp_rsp.push_back({(i == int'(len) - 1), v});
            end
        end
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (!(exp_rsp.size() == 0 && cmd_ready) && t < 3000) begin tick(); t++; end
        check(tag, 64'(t < 3000), 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_last"},  64'(rsp_last),  64'd0);
        check({tag, "_rsp_data"},  64'(rsp_data),  64'd0);
        check({tag, "_init_done"}, 64'(init_done), 64'd0);
        check({tag, "_cmd_err"},   64'(cmd_err),   64'd0);
        check({tag, "_reqs"},      64'({rd_req, wr_req}), 64'd0);
        check({tag, "_addr"},      64'(addr),      64'd0);
        check({tag, "_wr_d"},      64'(wr_d),      64'd0);
        check({tag, "_be"},        64'(wr_byte_en), 64'd0);
        check({tag, "_len"},       64'(rd_num_dwords), 64'd0);
        check({tag, "_space"},     64'(mem_or_reg), 64'd0);
        check({tag, "_lat1x"},     64'(latency_1x), 64'h10);
        check({tag, "_lat2x"},     64'(latency_2x), 64'd22);
    endtask

    task automatic power_up();
        int t;
        reset_l = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; bp_rand = 1'b0;
        exp_req.delete();
        exp_rsp.delete();
        repeat (3) tick();
        check_reset_vals("rst");
        exp_req.push_back('{rd: 1'b0, reg_sp: 1'b1, a: 32'h800, d: 32'h8F1F_0000, be: 4'hC, len: 6'd0});
        reset_l = 1'b1;
        repeat (20) tick();
        check("init_early", 64'(wr_req), 64'd0);
        tick();
        check("init_wr_req", 64'(wr_req), 64'd1);
        check("init_addr", 64'(addr), 64'h800);
        check("init_wr_d", 64'(wr_d), 64'h8F1F_0000);
        check("init_be", 64'(wr_byte_en), 64'hC);
        check("init_space", 64'(mem_or_reg), 64'd1);
        check("init_ready_low", 64'(cmd_ready), 64'd0);
        tick();
        check("init_req_width", 64'(wr_req), 64'd0);
        check("init_done_early", 64'(init_done), 64'd0);
        t = 0;
        while (!init_done && t < 100) begin
            check("init_ready_hold", 64'(cmd_ready), 64'd0);
            tick(); t++;
        end
        check("init_done_rise", 64'(init_done), 64'd1);
        check("init_ready", 64'(cmd_ready), 64'd1);
    endtask

    // ---------------- directed sequence ------------------------------------
    int r0;
    int p0;
    int n0;
    int t0;
    logic [1:0] rop;

    initial begin
        // Power-up and CR0 write
        power_up();

        // Write then read, with issue timing and pulse width
        rsp_ready = 1'b1;
        send_cmd(OP_WR, 32'h10, 32'hDEAD_BEEF, 4'hF, 6'd0);
        check("wr_issue_wait", 64'(wr_req), 64'd0);
        tick();
        check("wr_issue_pulse", 64'(wr_req), 64'd1);
        tick();
        check("wr_pulse_width", 64'(wr_req), 64'd0);
        send_cmd(OP_RD, 32'h10, 32'h0, 4'h0, 6'd1);
        wait_drain("wr_rd_drain");

        // Burst read held by back-pressure, then a read that must stall
        rsp_ready = 1'b0;
        p0 = pop_cnt;
        send_cmd(OP_RD, 32'h100, 32'h0, 4'h0, 6'd4);
        t0 = 0;
        while (!cmd_ready && t0 < 500) begin tick(); t0++; end
        repeat (20) tick();
        check("bp_valid_held", 64'(rsp_valid), 64'd1);
        check("bp_no_pop", 64'(pop_cnt - p0), 64'd0);
        r0 = req_cnt;
        send_cmd(OP_RD, 32'h200, 32'h0, 4'h0, 6'd30);
        repeat (15) tick();
        check("stall_none_popped", 64'(req_cnt - r0), 64'd0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        repeat (5) tick();
        check("stall_one_popped", 64'(req_cnt - r0), 64'd0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        repeat (3) tick();
        check("stall_release", 64'(req_cnt - r0), 64'd1);
        rsp_ready = 1'b1;
        wait_drain("burst_drain");
        check("burst_pops", 64'(pop_cnt - p0), 64'd34);

        // Randomized traffic with random back-pressure
        bp_rand = 1'b1;
        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 2));
            send_cmd(rop, 32'($urandom_range(0, 15)), $urandom(), 4'($urandom_range(1, 15)),
                     6'($urandom_range(1, 8)));
        end
        bp_rand = 1'b0;
        rsp_ready = 1'b1;
        wait_drain("rand_drain");
        check("rand_req_queue", 64'(exp_req.size()), 64'd0);

        // Illegal commands
        check("err_clear", 64'(cmd_err), 64'd0);
        r0 = req_cnt;
        send_cmd(OP_BAD, 32'h0, 32'h0, 4'h0, 6'd1);
        tick();
        check("err_op11", 64'(cmd_err), 64'd1);
        send_cmd(OP_RD, 32'h0, 32'h0, 4'h0, 6'd40);
        repeat (10) tick();
        check("illegal_no_req", 64'(req_cnt - r0), 64'd0);
        check("illegal_ready", 64'(cmd_ready), 64'd1);
        check("illegal_no_rsp", 64'(rsp_valid), 64'd0);

        // Reset in the middle of a read
        rsp_ready = 1'b0;
        n0 = rd_pulses;
        send_cmd(OP_RD, 32'h40, 32'h0, 4'h0, 6'd8);
        t0 = 0;
        while (rd_pulses < n0 + 3 && t0 < 500) begin tick(); t0++; end
        check("mid_read_reached", 64'(rd_pulses - n0), 64'd3);
        check("mid_read_valid", 64'(rsp_valid), 64'd1);
        reset_l = 1'b0;
        #1;
        check_reset_vals("async");
        power_up();
        check("reinit_fifo_empty", 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b1;
        send_cmd(OP_RD, 32'h10, 32'h0, 4'h0, 6'd2);
        wait_drain("reinit_drain");

        // Stray read strobe with no read outstanding
        check("spur_err_before", 64'(cmd_err), 64'd0);
        spur_req++;
        repeat (4) tick();
        check("spur_err", 64'(cmd_err), 64'd1);
        check("spur_dropped", 64'(rsp_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hyper_cmd_seq.md
# hyper_cmd_seq

Command sequencer sitting directly upstream of the `hyper_xface` HyperRAM controller.
- After reset it waits out the HyperRAM power-up time, then writes configuration register CR0.
- It then accepts host commands on a valid/ready port and converts each into one `rd_req`/`wr_req` transaction on the controller.
- Read dwords returned on `rd_rdy` are buffered in a response FIFO with a valid/ready output, so the host may back-pressure even though the controller cannot.

## Interface
Parameters:
- INIT_CYCLES, 24900: cycles from reset release to CR0 write (150 us at 166 MHz).
- CR0_ADDR, 32'h0000_0800: register-space address of CR0.
- CR0_VALUE, 16'h8F1F: value written to CR0.
- LAT_1X, 8'h10: value driven on `latency_1x`.
- LAT_2X, 8'd22: value driven on `latency_2x`.
- RSP_DEPTH, 32: response FIFO depth in dwords; power of two, at least 2.

Ports:
- clk  in  1  single clock for all logic.
- reset_l  in  1  asynchronous active-low reset.
- cmd_valid / cmd_ready  in / out  1 / 1  host command handshake.
- cmd_op  in  2  00 read mem, 01 write mem, 10 write reg, 11 illegal.
- cmd_addr  in  32  dword address.
- cmd_data  in  32  write data.
- cmd_be  in  4  write byte enables.
- cmd_len  in  6  read length in dwords; 0 is treated as 1.
- rsp_valid / rsp_ready  out / in  1 / 1  read-data handshake.
- rsp_data  out  32  read dword.
- rsp_last  out  1  final dword of a read command.
- init_done  out  1  high once the CR0 write has completed; stays high.
- cmd_err  out  1  sticky error flag; cleared only by reset.
- rd_req, wr_req  out  1  single-cycle request pulses to the controller.
- mem_or_reg  out  1  0 = memory, 1 = register space.
- wr_byte_en  out  4.
- rd_num_dwords  out  6.
- addr  out  32.
- wr_d  out  32.
- rd_d  in  32.
- rd_rdy  in  1.
- busy  in  1.
- latency_1x, latency_2x  out  8  constants LAT_1X and LAT_2X.

## Operation
- FSM states: INIT_WAIT → INIT_ISSUE → WAIT_BUSY → WAIT_DONE → IDLE → ISSUE → WAIT_BUSY → WAIT_DONE → IDLE.
- **INIT_WAIT:** a counter runs INIT_CYCLES cycles after reset release.
- **INIT_ISSUE:** drives `mem_or_reg`=1, `addr`=CR0_ADDR, `wr_d`={CR0_VALUE,16'h0}, `wr_byte_en`=4'hC, and pulses `wr_req`.
  - `init_done` sets when the WAIT_DONE that follows INIT_ISSUE exits.
- **IDLE:** `cmd_ready`=1 only in IDLE with `init_done`=1; the accepted command is latched.
- **Illegal commands** (op 11, or read length > RSP_DEPTH):
  - the command is consumed, `cmd_err` sets, and the FSM stays in IDLE;
  - no request is issued.
- **ISSUE:** pulses the request only when `busy`=0, and for reads only when FIFO free space ≥ len. Free space = RSP_DEPTH − occupancy; nothing else is pending at ISSUE time.
  - Otherwise ISSUE holds.
  - Controller outputs hold the latched values from ISSUE until the next ISSUE.
  - Read: `mem_or_reg`=0, `rd_num_dwords`=len.
  - Write mem: `mem_or_reg`=0, `wr_byte_en`=be.
  - Write reg: `mem_or_reg`=1, `wr_byte_en`=4'hF.
- **WAIT_BUSY:** waits for `busy`=1.
- **WAIT_DONE:** exits to IDLE when `busy`=0 and, for reads, the received-dword count equals len.
- **Read data path:**
  - Each `rd_rdy` pulse while a read is outstanding pushes `rd_d` into the FIFO, tagged last on the len-th dword.
  - `rd_rdy` with no read outstanding, or beyond len, is dropped and sets `cmd_err`.
- **FIFO:** pointers are log2(RSP_DEPTH)+1 bits. Full/empty come from the MSB compare; wrap-around is natural. Push and pop in the same cycle leave occupancy unchanged. The FIFO can never overflow by construction.

## Timing
- **Reset values:**
  - all req pulses, `cmd_ready`, `rsp_valid`, `rsp_last`, `init_done`, `cmd_err` = 0;
  - `addr`, `wr_d`, `wr_byte_en`, `rd_num_dwords`, `mem_or_reg`, `rsp_data` = 0;
  - `latency_*` constant.
- **Init:** `wr_req` for CR0 pulses in cycle INIT_CYCLES+1 after reset deassertion, provided `busy`=0.
- **Command accepted at edge N:**
  - ISSUE is state at N+1; the req pulse is high during the cycle after N+1 if the ISSUE condition holds, else later.
  - Req width is exactly one cycle.
- **Response:** `rsp_valid` rises the cycle after the push edge. A pop happens on the `rsp_valid`&`rsp_ready` edge.
- **`rd_rdy` on the same edge as exit to IDLE:** the dword is still counted.
- **Reset mid-transaction:** asynchronous clear of FSM, FIFO and counters; the controller is expected to be reset by the same `reset_l`.

## Test plan
- **Power-up:** INIT_CYCLES=20. `wr_req` pulses once at cycle 21 with `addr`=0x800, `wr_d`=0x8F1F0000, `wr_byte_en`=C, `mem_or_reg`=1. `init_done` rises after `busy` falls; `cmd_ready` is 0 before that.
- **Write then read:** write addr 0x10, data 0xDEADBEEF, be F; then read addr 0x10, len 1. Model returns 0xDEADBEEF with `rsp_last`=1.
- **Burst read with back-pressure:** read len 4 while `rsp_ready` is held low for 20 cycles. All 4 dwords are retained, popped in order, `rsp_last` only on the 4th. A second read len 30 with RSP_DEPTH=32 stalls in ISSUE until 2 dwords are popped.
- **Illegal command:** op 11, then read len 40 with RSP_DEPTH=32. Both are consumed, no `rd_req`/`wr_req` issued, `cmd_err`=1.
- **Reset mid-read:** assert `reset_l`=0 during a len-8 read after 3 dwords. All outputs return to reset values asynchronously, the FIFO is empty, and INIT is repeated.
